// File: rtl/trail_collision.sv
// trail_collision: once per frame, reads the frame-buffer word under each
// bike's new head cell and raises a sticky collision flag on a non-zero word
// (trail), on a head outside the play area (wall), or on a head-on meeting.
module trail_collision #(
   parameter int         WORDS_PER_LINE = 320,
   parameter int         OFFSET         = 14,
   parameter int         CELL_PX        = 4,
   parameter int         GRID_MAX       = 112,
   parameter int         READ_LATENCY   = 2,
   parameter logic [2:0] PLAYING        = 3'b010
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [2:0]  Game_State,
   input  logic [7:0]  Blue_X,
   input  logic [7:0]  Blue_Y,
   input  logic [7:0]  Red_X,
   input  logic [7:0]  Red_Y,
   output logic        rd_req,
   output logic [19:0] rd_addr,
   input  logic        rd_gnt,
   input  logic [15:0] rd_data,
   output logic        collision_blue,
   output logic        collision_red,
   output logic        check_done,
   output logic        busy
);

   localparam logic [19:0] WPL  = 20'(WORDS_PER_LINE);
   localparam logic [19:0] OFS  = 20'(OFFSET);
   localparam logic [19:0] CPX  = 20'(CELL_PX);
   localparam logic [7:0]  GMAX = 8'(GRID_MAX);
   localparam logic [2:0]  RLAT = 3'(READ_LATENCY);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_REQ_B, S_WAIT_B, S_REQ_R, S_WAIT_R, S_RESOLVE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  fsync_q, fsync_d;
   logic        play_q, play_d;
   logic [7:0]  bx_q, by_q, rx_q, ry_q, bx_d, by_d, rx_d, ry_d;
   logic [7:0]  lbx_q, lby_q, lrx_q, lry_q, lbx_d, lby_d, lrx_d, lry_d;
   logic        moved_b_q, moved_r_q, wall_b_q, wall_r_q, head_q;
   logic        moved_b_d, moved_r_d, wall_b_d, wall_r_d, head_d;
   logic        hit_b_q, hit_r_q, hit_b_d, hit_r_d;
   logic        col_b_q, col_r_q, col_b_d, col_r_d;
   logic [2:0]  cnt_q, cnt_d;

   logic        playing, enter, frame_edge;
   logic        moved_b, moved_r, wall_b, wall_r, head_on;
   logic [19:0] addr_b, addr_r;

   // Word address of a grid cell; two pixels per word, hence the shift.
   function automatic logic [19:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
      cell_addr = (OFS + CPX * {12'd0, y}) * WPL + ((OFS + CPX * {12'd0, x}) >> 1);
   endfunction

   assign playing    = (Game_State == PLAYING);
   assign enter      = playing & ~play_q;
   // bits 0,1 are the synchroniser, bit 2 holds the previous synced value
   assign frame_edge = fsync_q[1] & ~fsync_q[2];

   assign moved_b = ({bx_q, by_q} != {lbx_q, lby_q});
   assign moved_r = ({rx_q, ry_q} != {lrx_q, lry_q});
   assign wall_b  = moved_b & ((bx_q >= GMAX) | (by_q >= GMAX));
   assign wall_r  = moved_r & ((rx_q >= GMAX) | (ry_q >= GMAX));
   assign head_on = moved_b & moved_r & ({bx_q, by_q} == {rx_q, ry_q});
   assign addr_b  = cell_addr(bx_q, by_q);
   assign addr_r  = cell_addr(rx_q, ry_q);

   assign collision_blue = col_b_q;
   assign collision_red  = col_r_q;
   assign busy           = (state_q != S_IDLE);

   // Next-state and output logic of the frame-check sequencer.
   always_comb begin
      state_d   = state_q;
      fsync_d   = {fsync_q[1:0], frame_clk};
      play_d    = playing;
      bx_d = bx_q;   by_d = by_q;   rx_d = rx_q;   ry_d = ry_q;
      lbx_d = lbx_q; lby_d = lby_q; lrx_d = lrx_q; lry_d = lry_q;
      moved_b_d = moved_b_q; moved_r_d = moved_r_q;
      wall_b_d  = wall_b_q;  wall_r_d  = wall_r_q;
      head_d    = head_q;
      hit_b_d   = hit_b_q;   hit_r_d   = hit_r_q;
      col_b_d   = col_b_q;   col_r_d   = col_r_q;
      cnt_d     = cnt_q;
      rd_req     = 1'b0;
      rd_addr    = 20'd0;
      check_done = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (frame_edge && playing && !col_b_q && !col_r_q) begin
               bx_d = Blue_X; by_d = Blue_Y; rx_d = Red_X; ry_d = Red_Y;
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            moved_b_d = moved_b; moved_r_d = moved_r;
            wall_b_d  = wall_b;  wall_r_d  = wall_r;
            head_d    = head_on;
            hit_b_d   = 1'b0;    hit_r_d   = 1'b0;
            if (moved_b && !wall_b)      state_d = S_REQ_B;
            else if (moved_r && !wall_r) state_d = S_REQ_R;
            else                         state_d = S_RESOLVE;
         end
         S_REQ_B: begin
            rd_req  = 1'b1;
            rd_addr = addr_b;
            if (rd_gnt) begin
               cnt_d   = 3'd1;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (cnt_q == RLAT) begin
               hit_b_d = (rd_data != 16'd0);
               state_d = (moved_r_q && !wall_r_q) ? S_REQ_R : S_RESOLVE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_REQ_R: begin
            rd_req  = 1'b1;
            rd_addr = addr_r;
            if (rd_gnt) begin
               cnt_d   = 3'd1;
               state_d = S_WAIT_R;
            end
         end
         S_WAIT_R: begin
            if (cnt_q == RLAT) begin
               hit_r_d = (rd_data != 16'd0);
               state_d = S_RESOLVE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_RESOLVE: begin
            col_b_d = col_b_q | wall_b_q | hit_b_q | head_q;
            col_r_d = col_r_q | wall_r_q | hit_r_q | head_q;
            lbx_d = bx_q; lby_d = by_q; lrx_d = rx_q; lry_d = ry_q;
            check_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Leaving the round aborts any check; flags keep the result for game-over.
      if (!playing) begin
         state_d    = S_IDLE;
         check_done = 1'b0;
         col_b_d    = col_b_q;
         col_r_d    = col_r_q;
      end

      // New round: clear flags and treat current heads as already checked.
      if (enter) begin
         col_b_d = 1'b0;
         col_r_d = 1'b0;
         lbx_d = Blue_X; lby_d = Blue_Y; lrx_d = Red_X; lry_d = Red_Y;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         fsync_q   <= 3'd0;
         play_q    <= 1'b0;
         bx_q <= 8'd0;  by_q <= 8'd0;  rx_q <= 8'd0;  ry_q <= 8'd0;
         lbx_q <= 8'd0; lby_q <= 8'd0; lrx_q <= 8'd0; lry_q <= 8'd0;
         moved_b_q <= 1'b0; moved_r_q <= 1'b0;
         wall_b_q  <= 1'b0; wall_r_q  <= 1'b0;
         head_q    <= 1'b0;
         hit_b_q   <= 1'b0; hit_r_q   <= 1'b0;
         col_b_q   <= 1'b0; col_r_q   <= 1'b0;
         cnt_q     <= 3'd0;
      end else begin
         state_q   <= state_d;
         fsync_q   <= fsync_d;
         play_q    <= play_d;
         bx_q <= bx_d;   by_q <= by_d;   rx_q <= rx_d;   ry_q <= ry_d;
         lbx_q <= lbx_d; lby_q <= lby_d; lrx_q <= lrx_d; lry_q <= lry_d;
         moved_b_q <= moved_b_d; moved_r_q <= moved_r_d;
         wall_b_q  <= wall_b_d;  wall_r_q  <= wall_r_d;
         head_q    <= head_d;
         hit_b_q   <= hit_b_d;   hit_r_q   <= hit_r_d;
         col_b_q   <= col_b_d;   col_r_q   <= col_r_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_trail_collision.sv
// Bench for trail_collision: SRAM/arbiter responder plus a frame-level model
// of the collision rules.
module tb_trail_collision;

   localparam logic [2:0] PLAYING = 3'b010;
   localparam int         RLAT    = 2;

   logic        Clk = 1'b0;
   logic        Reset, frame_clk;
   logic [2:0]  Game_State;
   logic [7:0]  Blue_X, Blue_Y, Red_X, Red_Y;
   logic        rd_req, rd_gnt;
   logic [19:0] rd_addr;
   logic [15:0] rd_data;
   logic        collision_blue, collision_red, check_done, busy;

   always #10 Clk = ~Clk;

   trail_collision dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
      .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
      .collision_blue(collision_blue), .collision_red(collision_red),
      .check_done(check_done), .busy(busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame-buffer contents; absent words read as zero.
   logic [15:0] mem [int];

   function automatic int addr_of(input int x, input int y);
      return (14 + 4 * y) * 320 + (14 + 4 * x) / 2;
   endfunction

   function automatic logic [15:0] mem_rd(input int a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   // Arbiter/SRAM responder, driven on the falling edge. Outside the valid
   // cycle rd_data carries non-zero junk.
   bit force_stall = 0;
   int wait_cnt = 0;
   int pend = 0;
   int pend_addr = 0;
   int gnt_q[$];
   int cd_cnt = 0;

   always @(negedge Clk) begin
      rd_data = 16'($urandom) | 16'h0001;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) rd_data = mem_rd(pend_addr);
      end
      rd_gnt = 1'b0;
      if (rd_req === 1'b1 && !force_stall) begin
         if (wait_cnt > 0) wait_cnt--;
         else begin
            rd_gnt = 1'b1;
            gnt_q.push_back(int'(rd_addr));
            pend      = RLAT;
            pend_addr = int'(rd_addr);
            wait_cnt  = $urandom_range(0, 3);
         end
      end
      if (check_done === 1'b1) cd_cnt++;
   end

   // Reference state: last checked heads, flags, current inputs.
   int cbx, cby, crx, cry;
   int lbx, lby, lrx, lry;
   bit fb, fr;

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic set_pos(input int bx, input int by, input int rx, input int ry);
      cbx = bx; cby = by; crx = rx; cry = ry;
      Blue_X = 8'(bx); Blue_Y = 8'(by); Red_X = 8'(rx); Red_Y = 8'(ry);
   endtask

   task automatic enter_play();
      @(negedge Clk);
      Game_State = 3'b001;
      cyc(2);
      Game_State = PLAYING;
      cyc(2);
      fb = 0; fr = 0;
      lbx = cbx; lby = cby; lrx = crx; lry = cry;
   endtask

   task automatic frame(input string tag, input int bx, input int by, input int rx, input int ry);
      int exp_q[$];
      bit ran, mb, mr, wb, wr, ho, hb, hr;
      @(negedge Clk);
      set_pos(bx, by, rx, ry);
      gnt_q.delete();
      cd_cnt = 0;
      frame_clk = 1'b1;
      cyc(4);
      frame_clk = 1'b0;
      cyc(60);
      ran = !fb && !fr;
      if (ran) begin
         mb = (bx != lbx) || (by != lby);
         mr = (rx != lrx) || (ry != lry);
         wb = mb && (bx >= 112 || by >= 112);
         wr = mr && (rx >= 112 || ry >= 112);
         ho = mb && mr && bx == rx && by == ry;
         hb = 0; hr = 0;
         if (mb && !wb) begin
            exp_q.push_back(addr_of(bx, by));
            hb = (mem_rd(addr_of(bx, by)) != 0);
         end
         if (mr && !wr) begin
            exp_q.push_back(addr_of(rx, ry));
            hr = (mem_rd(addr_of(rx, ry)) != 0);
         end
         fb = fb | wb | hb | ho;
         fr = fr | wr | hr | ho;
         lbx = bx; lby = by; lrx = rx; lry = ry;
      end
      chk({tag, ".done"}, cd_cnt, 32'(ran));
      chk({tag, ".nrd"}, gnt_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < gnt_q.size()) chk({tag, ".addr"}, gnt_q[i], exp_q[i]);
      chk({tag, ".colb"}, collision_blue, fb);
      chk({tag, ".colr"}, collision_red, fr);
      chk({tag, ".busy"}, busy, 0);
   endtask

   initial begin
      int a0, nbx, nby, nrx, nry, r;
      Reset = 1'b1; frame_clk = 1'b0; Game_State = 3'b000;
      set_pos(0, 0, 0, 0);
      cyc(3);
      chk("rst.req", rd_req, 0);
      chk("rst.addr", rd_addr, 0);
      chk("rst.colb", collision_blue, 0);
      chk("rst.colr", collision_red, 0);
      chk("rst.done", check_done, 0);
      chk("rst.busy", busy, 0);
      Reset = 1'b0;
      cyc(2);

      // clear path
      set_pos(10, 10, 80, 80);
      enter_play();
      frame("clear", 11, 10, 79, 80);
      chk("clear.addr_b_abs", addr_of(11, 10), 17309);

      // trail hit, then flag persists with no further checks
      set_pos(10, 10, 80, 80);
      enter_play();
      mem[107045] = 16'h0F00;
      frame("trail", 11, 10, 79, 80);
      chk("trail.colr_abs", collision_red, 1);
      frame("persist1", 12, 10, 78, 80);
      frame("persist2", 13, 10, 77, 80);
      frame("persist3", 14, 10, 76, 80);
      mem.delete();

      // wall
      set_pos(110, 20, 30, 30);
      enter_play();
      frame("wall", 112, 20, 31, 30);

      // head-on
      set_pos(49, 60, 51, 60);
      enter_play();
      frame("headon", 50, 60, 50, 60);

      // red stationary
      set_pos(20, 20, 40, 40);
      enter_play();
      frame("still", 21, 20, 40, 40);

      // stall then abort
      set_pos(20, 20, 40, 40);
      enter_play();
      force_stall = 1;
      @(negedge Clk);
      set_pos(21, 20, 41, 40);
      gnt_q.delete();
      cd_cnt = 0;
      frame_clk = 1'b1;
      for (int i = 0; i < 20 && rd_req !== 1'b1; i++) cyc(1);
      chk("stall.req_seen", rd_req, 1);
      a0 = int'(rd_addr);
      chk("stall.addr0", a0, addr_of(21, 20));
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("stall.req", rd_req, 1);
         chk("stall.addr", rd_addr, a0);
      end
      Game_State = 3'b011;
      cyc(1);
      chk("abort.req", rd_req, 0);
      chk("abort.busy", busy, 0);
      frame_clk = 1'b0;
      force_stall = 0;
      cyc(5);
      chk("abort.done", cd_cnt, 0);
      chk("abort.colb", collision_blue, fb);
      chk("abort.colr", collision_red, fr);

      // reset during WAIT_B; the late read data must be ignored
      mem[addr_of(21, 20)] = 16'h1234;
      set_pos(20, 20, 40, 40);
      enter_play();
      @(negedge Clk);
      set_pos(21, 20, 40, 40);
      gnt_q.delete();
      cd_cnt = 0;
      frame_clk = 1'b1;
      for (int i = 0; i < 30 && gnt_q.size() == 0; i++) cyc(1);
      chk("rstmid.gnt_seen", gnt_q.size(), 1);
      cyc(1);
      frame_clk = 1'b0;
      Reset = 1'b1;
      cyc(2);
      Reset = 1'b0;
      chk("rstmid.req", rd_req, 0);
      chk("rstmid.addr", rd_addr, 0);
      chk("rstmid.busy", busy, 0);
      chk("rstmid.colb", collision_blue, 0);
      cyc(10);
      chk("rstmid.colb_late", collision_blue, 0);
      chk("rstmid.colr_late", collision_red, 0);
      chk("rstmid.done", cd_cnt, 0);
      mem.delete();

      // randomized frames
      set_pos($urandom_range(0, 100), $urandom_range(0, 100),
              $urandom_range(0, 100), $urandom_range(0, 100));
      enter_play();
      for (int it = 0; it < 40; it++) begin
         if (fb || fr) begin
            set_pos($urandom_range(0, 100), $urandom_range(0, 100),
                    $urandom_range(0, 100), $urandom_range(0, 100));
            enter_play();
         end
         nbx = cbx; nby = cby; nrx = crx; nry = cry;
         r = $urandom_range(0, 9);
         if (r >= 2 && r <= 7) begin
            case ($urandom_range(0, 3))
               0: nbx = nbx + 1;
               1: nbx = (nbx > 0) ? nbx - 1 : 1;
               2: nby = nby + 1;
               default: nby = (nby > 0) ? nby - 1 : 1;
            endcase
         end else if (r == 8) begin
            if ($urandom_range(0, 1) == 1) nbx = $urandom_range(112, 255);
            else nby = $urandom_range(112, 255);
         end else if (r == 9) begin
            nbx = $urandom_range(0, 111); nby = $urandom_range(0, 111);
         end
         r = $urandom_range(0, 9);
         if (r >= 2 && r <= 7) begin
            case ($urandom_range(0, 3))
               0: nrx = nrx + 1;
               1: nrx = (nrx > 0) ? nrx - 1 : 1;
               2: nry = nry + 1;
               default: nry = (nry > 0) ? nry - 1 : 1;
            endcase
         end else if (r == 8) begin
            if ($urandom_range(0, 1) == 1) nrx = $urandom_range(112, 255);
            else nry = $urandom_range(112, 255);
         end else if (r == 9) begin
            nrx = nbx; nry = nby;
         end
         if ($urandom_range(0, 9) < 3) mem[addr_of(nbx, nby)] = 16'($urandom_range(1, 65535));
         else mem[addr_of(nbx, nby)] = 16'h0000;
         if ($urandom_range(0, 9) < 3) mem[addr_of(nrx, nry)] = 16'($urandom_range(1, 65535));
         else mem[addr_of(nrx, nry)] = 16'h0000;
         frame("rand", nbx, nby, nrx, nry);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
